dispatch_stage: RTL

//  Consumes the FETCH_W-wide renamed bundle from rename_stage and holds it in one bundle register.

---
 rtl/dispatch_stage_pkg.sv | 41 ++++
 rtl/dispatch_stage_if.sv | 12 +
 rtl/dispatch_stage_busy_table.sv | 54 +++++
 rtl/dispatch_stage.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dispatch_stage_pkg.sv
// Shared types and sizing for the dispatch stage slice.
package dispatch_stage_pkg;

  localparam int FETCH_W   = 2;
  localparam int PHYS_REGS = 48;
  localparam int PREG_W    = 6;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int CDB_W     = 2;
  localparam int CNT_W     = ROB_IDX_W + 1;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic [4:0]        arch_rd;
    logic [31:0]       imm;
    logic [31:0]       pc;
    logic              rs1_valid;
    logic              rs2_valid;
    logic              rd_valid;
    logic              is_alu;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              is_cas;
    logic [3:0]        alu_func;
  } uop_t;

  // ALU and branch uops wait in the issue queue.
  function automatic logic needs_iq(uop_t u);
    return u.is_alu | u.is_branch;
  endfunction

  // Memory uops (including CAS) take an LSQ slot.
  function automatic logic needs_lsq(uop_t u);
    return u.is_load | u.is_store | u.is_cas;
  endfunction

endpackage

// File: rtl/dispatch_stage_if.sv
// Rename -> dispatch bundle handshake.
interface dispatch_stage_if;
  import dispatch_stage_pkg::*;

  logic [FETCH_W-1:0] ren_valid;
  uop_t [FETCH_W-1:0] ren_uop;
  logic               disp_ready;

  modport master (output ren_valid, output ren_uop, input disp_ready);
  modport slave  (input ren_valid, input ren_uop, output disp_ready);

endinterface

// File: rtl/dispatch_stage_busy_table.sv
// Physical-register busy bits with writeback clear, dispatch set and bypassed reads.
module dispatch_stage_busy_table
  import dispatch_stage_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [FETCH_W-1:0]                  set_en,
  input  logic [FETCH_W-1:0][PREG_W-1:0]      set_tag,
  input  logic [CDB_W-1:0]                    wb_valid,
  input  logic [CDB_W-1:0][PREG_W-1:0]        wb_prd,
  input  logic [2*FETCH_W-1:0][PREG_W-1:0]    rd_tag,
  output logic [2*FETCH_W-1:0]                rd_rdy
);

  logic [PHYS_REGS-1:0]  busy;
  logic [PHYS_REGS-1:0]  set_vec;
  logic [PHYS_REGS-1:0]  clr_vec;
  logic [2*FETCH_W-1:0]  rd_busy;
  logic [2*FETCH_W-1:0]  rd_wake;

  // Decode set/clear tags into per-register vectors; register 0 can never be set.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int r = 0; r < PHYS_REGS; r++) begin
      for (int i = 0; i < FETCH_W; i++)
        if (r != 0 && set_en[i] && set_tag[i] == PREG_W'(r)) set_vec[r] = 1'b1;
      for (int k = 0; k < CDB_W; k++)
        if (wb_valid[k] && wb_prd[k] == PREG_W'(r)) clr_vec[r] = 1'b1;
    end
  end

  // Set wins over a same-cycle clear; flush wipes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= (busy & ~clr_vec) | set_vec;
  end

  // Read ports: ready unless busy, with a same-cycle wakeup bypass.
  always_comb begin
    rd_busy = '0;
    rd_wake = '0;
    for (int p = 0; p < 2*FETCH_W; p++) begin
      for (int r = 0; r < PHYS_REGS; r++)
        if (busy[r] && rd_tag[p] == PREG_W'(r)) rd_busy[p] = 1'b1;
      for (int k = 0; k < CDB_W; k++)
        if (wb_valid[k] && wb_prd[k] == rd_tag[p]) rd_wake[p] = 1'b1;
    end
    rd_rdy = ~rd_busy | rd_wake;
  end

endmodule

// File: rtl/dispatch_stage.sv
// Holds one renamed bundle and dispatches it all-or-nothing to ROB / IQ / LSQ.
module dispatch_stage
  import dispatch_stage_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  dispatch_stage_if.slave                    ren,
  input  logic [CNT_W-1:0]                   rob_free_cnt,
  input  logic [ROB_IDX_W-1:0]               rob_tail,
  input  logic [3:0]                         iq_free_cnt,
  input  logic [3:0]                         lsq_free_cnt,
  output logic [FETCH_W-1:0]                 rob_alloc,
  output logic [FETCH_W-1:0]                 iq_alloc,
  output logic [FETCH_W-1:0]                 lsq_alloc,
  output uop_t [FETCH_W-1:0]                 disp_uop,
  output logic [FETCH_W-1:0][ROB_IDX_W-1:0]  disp_rob_idx,
  output logic [FETCH_W-1:0]                 disp_rs1_rdy,
  output logic [FETCH_W-1:0]                 disp_rs2_rdy,
  input  logic [CDB_W-1:0]                   wb_valid,
  input  logic [CDB_W-1:0][PREG_W-1:0]       wb_prd
);

  logic [FETCH_W-1:0]                held_valid;
  uop_t [FETCH_W-1:0]                held_uop;
  logic [FETCH_W-1:0]                want_iq;
  logic [FETCH_W-1:0]                want_lsq;
  logic [CNT_W-1:0]                  n_rob;
  logic [CNT_W-1:0]                  n_iq;
  logic [CNT_W-1:0]                  n_lsq;
  logic                              held_any;
  logic                              fire;
  logic                              accept;
  logic [ROB_IDX_W-1:0]              rank;
  logic [FETCH_W-1:0]                dep_rs1;
  logic [FETCH_W-1:0]                dep_rs2;
  logic [FETCH_W-1:0]                set_en;
  logic [FETCH_W-1:0][PREG_W-1:0]    set_tag;
  logic [2*FETCH_W-1:0][PREG_W-1:0]  rd_tag;
  logic [2*FETCH_W-1:0]              tbl_rdy;

  // Resource demand of the held bundle and the all-or-nothing fire decision.
  always_comb begin
    want_iq  = '0;
    want_lsq = '0;
    n_rob    = '0;
    n_iq     = '0;
    n_lsq    = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      want_iq[i]  = held_valid[i] & needs_iq(held_uop[i]);
      want_lsq[i] = held_valid[i] & needs_lsq(held_uop[i]);
      n_rob = n_rob + CNT_W'(held_valid[i]);
      n_iq  = n_iq  + CNT_W'(want_iq[i]);
      n_lsq = n_lsq + CNT_W'(want_lsq[i]);
    end
    held_any = |held_valid;
    fire = held_any && !flush
           && (rob_free_cnt >= n_rob)
           && (CNT_W'(iq_free_cnt)  >= n_iq)
           && (CNT_W'(lsq_free_cnt) >= n_lsq);
    accept = !flush && (!held_any || fire);
  end

  assign rob_alloc      = {FETCH_W{fire}} & held_valid;
  assign iq_alloc       = {FETCH_W{fire}} & want_iq;
  assign lsq_alloc      = {FETCH_W{fire}} & want_lsq;
  assign disp_uop       = held_uop;
  assign ren.disp_ready = accept;

  // ROB index = tail + rank among valid lanes; empty lanes get no index.
  always_comb begin
    rank         = '0;
    disp_rob_idx = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (held_valid[i]) begin
        disp_rob_idx[i] = rob_tail + rank;
        rank            = rank + ROB_IDX_W'(1);
      end
    end
  end

  // Intra-bundle RAW detection and final operand-ready (dependency beats bypass).
  always_comb begin
    dep_rs1      = '0;
    dep_rs2      = '0;
    rd_tag       = '0;
    set_en       = '0;
    set_tag      = '0;
    disp_rs1_rdy = '0;
    disp_rs2_rdy = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      rd_tag[2*i]   = held_uop[i].prs1;
      rd_tag[2*i+1] = held_uop[i].prs2;
      set_en[i]     = rob_alloc[i] & held_uop[i].rd_valid & (held_uop[i].prd != '0);
      set_tag[i]    = held_uop[i].prd;
      for (int j = 0; j < FETCH_W; j++) begin
        if (j < i && held_valid[j] && held_uop[j].rd_valid) begin
          if (held_uop[j].prd == held_uop[i].prs1) dep_rs1[i] = 1'b1;
          if (held_uop[j].prd == held_uop[i].prs2) dep_rs2[i] = 1'b1;
        end
      end
      disp_rs1_rdy[i] = !held_uop[i].rs1_valid || (held_uop[i].prs1 == '0)
                        || (!dep_rs1[i] && tbl_rdy[2*i]);
      disp_rs2_rdy[i] = !held_uop[i].rs2_valid || (held_uop[i].prs2 == '0)
                        || (!dep_rs2[i] && tbl_rdy[2*i+1]);
    end
  end

  // Bundle register: load on accept, hold on stall, drop on flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_valid <= '0;
      held_uop   <= '0;
    end else if (flush) begin
      held_valid <= '0;
    end else if (accept) begin
      held_valid <= ren.ren_valid;
      held_uop   <= ren.ren_uop;
    end
  end

  dispatch_stage_busy_table u_busy (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .set_en   (set_en),
    .set_tag  (set_tag),
    .wb_valid (wb_valid),
    .wb_prd   (wb_prd),
    .rd_tag   (rd_tag),
    .rd_rdy   (tbl_rdy)
  );

endmodule
